// File: rtl/preset_entry.sv
// rtl/preset_entry.sv - debounced four-button editor for a 4-digit BCD countdown preset
// Optional hold-to-repeat on UP/DOWN while editing: define PRESET_AUTO_REPEAT_EN.
module preset_entry #(
   parameter int          DEBOUNCE_CYCLES = 1000000,
   parameter int          CNT_BITS        = 20,
   parameter logic [15:0] INIT            = 16'h0060,
   parameter int          REPEAT_DELAY    = 50000000,
   parameter int          REPEAT_PERIOD   = 10000000
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        CE,
   input  logic        BTN_UP,
   input  logic        BTN_DOWN,
   input  logic        BTN_NEXT,
   input  logic        BTN_LOAD,
   input  logic        RUNNING,
   output logic [15:0] Q,
   output logic [3:0]  SEL,
   output logic        EDIT,
   output logic        LOAD
);

   localparam int B_UP   = 0;
   localparam int B_DOWN = 1;
   localparam int B_NEXT = 2;
   localparam int B_LOAD = 3;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_BITS) <= 64'(DEBOUNCE_CYCLES) ||
       REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_params
      $error("preset_entry: invalid parameter set");
   end

   typedef enum logic {IDLE, EDITING} state_t;
   state_t state;

   logic [3:0]          raw;
   logic [3:0]          sync1;
   logic [3:0]          sync2;
   logic [3:0]          acc;
   logic [3:0]          acc_q;
   logic [3:0]          evt;
   logic [CNT_BITS-1:0] cnt [4];

   assign raw = {BTN_LOAD, BTN_NEXT, BTN_DOWN, BTN_UP};

   // Accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         sync1 <= '0;
         sync2 <= '0;
         acc   <= '0;
         acc_q <= '0;
         evt   <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else if (CE) begin
         sync1 <= raw;
         sync2 <= sync1;
         acc_q <= acc;
         evt   <= acc & ~acc_q;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == acc[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               acc[i] <= ~acc[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_BITS'(1);
            end
         end
      end
   end

   logic rpt_up;
   logic rpt_down;

`ifdef PRESET_AUTO_REPEAT_EN
   logic [31:0] rpt_cnt;

   // After the first repeat the counter restarts PERIOD short of the firing point.
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         rpt_cnt  <= '0;
         rpt_up   <= 1'b0;
         rpt_down <= 1'b0;
      end else if (CE) begin
         rpt_up   <= 1'b0;
         rpt_down <= 1'b0;
         if (state != EDITING || RUNNING || evt != 4'b0000 || !(acc[B_UP] || acc[B_DOWN])) begin
            rpt_cnt <= '0;
         end else if (rpt_cnt == 32'(REPEAT_DELAY - 1)) begin
            rpt_cnt  <= 32'(REPEAT_DELAY - REPEAT_PERIOD);
            rpt_up   <= acc[B_UP];
            rpt_down <= ~acc[B_UP];
         end else begin
            rpt_cnt <= rpt_cnt + 32'd1;
         end
      end
   end
`else
   assign rpt_up   = 1'b0;
   assign rpt_down = 1'b0;
`endif

   logic do_up;
   logic do_down;

   assign do_up   = evt[B_UP] | rpt_up;
   assign do_down = evt[B_DOWN] | rpt_down;

   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d >= 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [3:0] bcd_dec(input logic [3:0] d);
      return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
   endfunction

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state <= IDLE;
         Q     <= INIT;
         SEL   <= 4'b0000;
         EDIT  <= 1'b0;
         LOAD  <= 1'b0;
      end else if (CE) begin
         LOAD <= 1'b0;
         if (RUNNING) begin
            state <= IDLE;
            SEL   <= 4'b0000;
            EDIT  <= 1'b0;
         end else if (state == IDLE) begin
            if (evt[B_LOAD]) begin
               LOAD <= 1'b1;
            end else if (evt[B_NEXT]) begin
               state <= EDITING;
               SEL   <= 4'b0001;
               EDIT  <= 1'b1;
            end
         end else begin
            if (evt[B_LOAD]) begin
               LOAD  <= 1'b1;
               state <= IDLE;
               SEL   <= 4'b0000;
               EDIT  <= 1'b0;
            end else if (evt[B_NEXT]) begin
               SEL <= {SEL[2:0], SEL[3]};
            end else if (do_up || do_down) begin
               for (int i = 0; i < 4; i++) begin
                  if (SEL[i]) Q[4*i +: 4] <= do_up ? bcd_inc(Q[4*i +: 4]) : bcd_dec(Q[4*i +: 4]);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_preset_entry.sv
// tb/tb_preset_entry.sv - directed-vector bench for preset_entry with a 4-cycle debounce
module tb_preset_entry;

   logic        CLK = 1'b0;
   logic        CLR;
   logic        CE;
   logic        BTN_UP;
   logic        BTN_DOWN;
   logic        BTN_NEXT;
   logic        BTN_LOAD;
   logic        RUNNING;
   logic [15:0] Q;
   logic [3:0]  SEL;
   logic        EDIT;
   logic        LOAD;

   int n_vec = 0;
   int n_bad = 0;

   preset_entry #(.DEBOUNCE_CYCLES(4), .CNT_BITS(3)) dut (
      .CLK(CLK), .CLR(CLR), .CE(CE),
      .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_NEXT(BTN_NEXT), .BTN_LOAD(BTN_LOAD),
      .RUNNING(RUNNING),
      .Q(Q), .SEL(SEL), .EDIT(EDIT), .LOAD(LOAD)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // mask bits: {LOAD, NEXT, DOWN, UP}
   task automatic press(input logic [3:0] mask, input int len);
      {BTN_LOAD, BTN_NEXT, BTN_DOWN, BTN_UP} = mask;
      tick(len);
      {BTN_LOAD, BTN_NEXT, BTN_DOWN, BTN_UP} = 4'b0000;
      tick(12);
   endtask

   localparam logic [3:0] P_UP   = 4'b0001;
   localparam logic [3:0] P_DOWN = 4'b0010;
   localparam logic [3:0] P_NEXT = 4'b0100;
   localparam logic [3:0] P_LOAD = 4'b1000;

   int first;
   int highs;
   logic [3:0] sel_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   initial begin
      CLR = 1'b0; CE = 1'b1; RUNNING = 1'b0;
      {BTN_LOAD, BTN_NEXT, BTN_DOWN, BTN_UP} = 4'b0000;
      tick(3);
      check("rst_q", Q, 16'h0060);
      check("rst_sel", SEL, 4'b0000);
      check("rst_edit", EDIT, 1'b0);
      check("rst_load", LOAD, 1'b0);
      CLR = 1'b1;
      tick(2);

      press(P_NEXT, 8);
      check("enter_edit", EDIT, 1'b1);
      check("enter_sel", SEL, 4'b0001);
      press(P_DOWN, 8);
      check("down_wrap", Q, 16'h0069);
      press(P_NEXT, 8);
      check("next_sel", SEL, 4'b0010);
      press(P_UP, 8);
      press(P_UP, 8);
      check("up_x2", Q, 16'h0089);

      BTN_LOAD = 1'b1;
      first = 0;
      highs = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (LOAD) begin
            highs++;
            if (first == 0) first = i;
         end
      end
      BTN_LOAD = 1'b0;
      tick(12);
      check("load_latency", first, 8);
      check("load_count", highs, 1);
      check("load_q", Q, 16'h0089);
      check("load_sel", SEL, 4'b0000);
      check("load_edit", EDIT, 1'b0);

      press(P_NEXT, 8);
      press(P_UP, 3);
      check("glitch_q", Q, 16'h0089);
      press(P_UP, 5);
      check("long_up_q", Q, 16'h0080);

      press(P_NEXT | P_UP, 8);
      check("prio_sel", SEL, 4'b0010);
      check("prio_q", Q, 16'h0080);

      press(P_NEXT, 8);
      check("d2_sel", SEL, 4'b0100);
      repeat (5) press(P_UP, 8);
      check("d2_q", Q, 16'h0580);
      RUNNING = 1'b1;
      tick(1);
      check("run_edit", EDIT, 1'b0);
      check("run_sel", SEL, 4'b0000);
      check("run_load", LOAD, 1'b0);
      check("run_q", Q, 16'h0580);
      BTN_LOAD = 1'b1;
      highs = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (LOAD) highs++;
      end
      BTN_LOAD = 1'b0;
      tick(12);
      check("run_load_press", highs, 0);
      RUNNING = 1'b0;
      tick(2);

      for (int i = 0; i < 5; i++) begin
         press(P_NEXT, 8);
         check($sformatf("wrap_sel%0d", i), SEL, sel_seq[i]);
      end

      BTN_UP = 1'b1;
      tick(7);
      CE = 1'b0;
      tick(5);
      check("ce_hold_q", Q, 16'h0580);
      CE = 1'b1;
      tick(1);
      check("ce_resume_q", Q, 16'h0581);
      BTN_UP = 1'b0;
      tick(12);
      check("ce_single_q", Q, 16'h0581);

      CLR = 1'b0;
      tick(1);
      CLR = 1'b1;
      check("midrst_q", Q, 16'h0060);
      check("midrst_edit", EDIT, 1'b0);
      check("midrst_sel", SEL, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/preset_entry.md
# preset_entry

Push-button front end for the countdown timer: debounces four raw buttons and lets the user edit a 4-digit BCD preset value, one digit at a time. It is the input-side counterpart of the 7-segment display path. Its outputs feed the seconds down-counter's preset (`Q`, `LOAD`) and the display driver's digit-highlight mask (`SEL`). All logic runs in the single system clock domain.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); must be ≥ 2.
- `CNT_BITS`, default 20: width of each debounce counter; must satisfy 2^`CNT_BITS` > `DEBOUNCE_CYCLES`.
- `INIT`, default 16'h0060: reset value of `Q`, as packed BCD.
- `REPEAT_DELAY`, default 50000000: hold time before auto-repeat starts. Used only with `PRESET_AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, default 10000000: interval between auto-repeat events. Used only with `PRESET_AUTO_REPEAT_EN`.

Ports:
- `CLK` in 1: system clock. One clock; all state is updated on the rising edge.
- `CLR` in 1: reset, synchronous, active-low.
- `CE` in 1: clock enable. While low, all state holds, including the synchronizers and debounce counters.
- `BTN_UP`, `BTN_DOWN`, `BTN_NEXT`, `BTN_LOAD` in 1 each: raw asynchronous buttons, active-high.
- `RUNNING` in 1: high while the timer is counting down.
- `Q` out 16: preset value as 4 packed BCD digits, with digit 0 in `Q[3:0]` (units).
- `SEL` out 4: one-hot cursor marking the digit being edited; all zeros when not editing.
- `EDIT` out 1: high in the EDIT state.
- `LOAD` out 1: one-cycle pulse requesting that the counter take `Q`.

## Operation

- **Synchronizer:** each button passes through a 2-FF synchronizer.
- **Debounce counter:** each button has its own counter.
  - When the synchronized level differs from the accepted level, the counter increments; otherwise it clears.
  - When the counter reaches `DEBOUNCE_CYCLES`, the accepted level toggles and the counter clears.
- **Press event:** a registered, one-cycle pulse on the 0→1 transition of the accepted level. Releases generate no event.
- **Event priority:** LOAD > NEXT > UP > DOWN. At most one action is taken per cycle; lower-priority events in the same cycle are discarded.
- **IDLE state:**
  - NEXT: go to EDIT, `SEL`=0001.
  - LOAD: pulse `LOAD`; `Q` is unchanged.
  - UP, DOWN: ignored.
- **EDIT state:**
  - UP: the selected digit increments, wrapping 9→0 with no carry into the neighbour.
  - DOWN: the selected digit decrements, wrapping 0→9 with no borrow.
  - NEXT: `SEL` rotates left, wrapping 1000→0001.
  - LOAD: pulse `LOAD`, go to IDLE, `SEL`=0000.
- **RUNNING high:** all events are discarded.
  - If the block is in EDIT, it goes to IDLE on the next enabled edge, with `SEL`=0000 and no `LOAD` pulse.
  - `Q` retains the edited digits.
- **Digit range:** digits are always within 0–9. Non-BCD `INIT` digits are not supported.
- **Reset (`CLR`=0 at an edge):**
  - Outputs: `Q`=`INIT`, `SEL`=0000, `EDIT`=0, `LOAD`=0, state IDLE.
  - Internals: synchronizers, accepted levels, debounce counters and repeat counters all 0.
  - A button held through reset is accepted as pressed `DEBOUNCE_CYCLES` after the synchronizer sees it, and then generates one event.

## Timing

- Raw input stable high from edge 0:
  - the synchronized level is valid after edge 2;
  - the accepted level toggles at edge 2+`DEBOUNCE_CYCLES`;
  - the event pulse is high in the following cycle;
  - `Q`, `SEL`, `EDIT` and `LOAD` update at the edge ending that cycle.
- Total latency is `DEBOUNCE_CYCLES`+4 edges.
- `LOAD` is high for exactly one `CE`-qualified cycle and is registered.
- Glitches shorter than `DEBOUNCE_CYCLES` clear the counter and produce no event.
- When `CE` is low, a pending event pulse is held and is consumed on the next enabled cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

- **`PRESET_AUTO_REPEAT_EN` defined:** in EDIT, with UP or DOWN accepted-high:
  - a repeat counter starts at the press event;
  - after `REPEAT_DELAY` cycles an extra UP/DOWN event is generated, then one every `REPEAT_PERIOD` cycles while the button stays accepted-high;
  - releasing the button, any other event, or leaving EDIT clears the counter;
  - if UP and DOWN are both held, only UP repeats.
- **Not defined:** the repeat logic is absent, and one press gives exactly one step.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

- **Reset:** hold `CLR`=0 for 3 cycles → `Q`=16'h0060, `SEL`=0, `EDIT`=0, `LOAD`=0.
- **Edit and load:** press NEXT, then press DOWN once (digit 0: 0→9), then press NEXT, then UP ×2 (digit 1: 6→8), then LOAD.
  - Expect `Q`=16'h0089 and `SEL` sequence 0001→0010→0000.
  - Expect a single `LOAD` pulse exactly 8 edges after the LOAD raw edge.
- **Glitch rejection:** 3-cycle UP pulse in EDIT → no `Q` change. Then a 5-cycle pulse → exactly one increment.
- **Priority:** NEXT and UP accepted in the same cycle while in EDIT → `SEL` rotates and the digit is unchanged.
- **RUNNING abort:** in EDIT with digit 2 edited to 5, raise `RUNNING`.
  - Expect IDLE next cycle, no `LOAD` pulse, and `Q[11:8]`=5.
  - A LOAD press while `RUNNING` is high → no pulse.
- **Cursor wrap and reset mid-edit:** NEXT ×5 → `SEL`=0001 (cursor has wrapped past 1000). Then `CLR`=0 for 1 cycle during EDIT → `Q`=16'h0060 and IDLE.
